traffic_phase_ctrl: RTL and testbench
=====================================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter N_LANES, default 4: number of approach lanes, legal range 2..8.
REQ-002 Parameter GREEN_CYC, default 5: clock cycles a lane shows green; legal value >=1.
REQ-003 Parameter YELLOW_CYC, default 2: clock cycles a lane shows yellow; legal value >=1.
REQ-004 Parameter ALLRED_CYC, default 1: clock cycles of all-red clearance between lanes; legal value >=1.
REQ-005 Parameter SKIP_EMPTY, default 0: 1 serves only lanes with a pending request; 0 uses fixed rotation.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port req, input, N_LANES bits: per-lane vehicle-demand level; used only when SKIP_EMPTY=1.
REQ-009 Port emg_req, input, 1 bit: emergency preemption request level.
REQ-010 Port emg_lane, input, 3 bits: lane to preempt to; values >= N_LANES are invalid.
REQ-011 Port lamp_r, output, N_LANES bits: red lamp per lane, active-high.
REQ-012 Port lamp_y, output, N_LANES bits: yellow lamp per lane, active-high.
REQ-013 Port lamp_g, output, N_LANES bits: green lamp per lane, active-high.
REQ-014 Port cur_lane, output, 3 bits: lane currently owning the phase.
REQ-015 Port emg_active, output, 1 bit: high while an emergency green is being held.

Function
REQ-016 FSM states are GREEN, YELLOW, ALLRED; cur_lane and a down-counter timer are registered alongside the state.
REQ-017 On entry to a state, the timer loads that state's duration minus 1; the state exits on the edge where the timer is 0, so each state lasts exactly its duration.
REQ-018 Transitions: GREEN->YELLOW->ALLRED on cur_lane, then ALLRED->GREEN on the next lane.
REQ-019 Next lane with SKIP_EMPTY=0: (cur_lane+1) mod N_LANES.
REQ-020 Next lane with SKIP_EMPTY=1: first lane with req=1, searching cur_lane+1 upward with wrap and checking cur_lane last.
REQ-021 If SKIP_EMPTY=1 and req is all zeros when ALLRED expires, the FSM stays in ALLRED, reloads the timer, and keeps cur_lane.
REQ-022 Preemption is valid only when emg_req=1 and emg_lane<N_LANES; otherwise emg_req is ignored.
REQ-023 Valid preemption in GREEN with cur_lane!=emg_lane: the FSM enters YELLOW on the next edge regardless of the timer.
REQ-024 Valid preemption in YELLOW or ALLRED: the state completes normally, and the next green lane is emg_lane, overriding REQ-019 and REQ-020.
REQ-025 Valid preemption in GREEN with cur_lane==emg_lane: GREEN holds with the timer frozen, and emg_active=1.
REQ-026 When preemption ends during a hold (emg_req falls or emg_lane changes), the FSM enters YELLOW on the next edge.
REQ-027 Outputs are registered and update on the same edge as the state, with no combinational path from inputs to outputs.
REQ-028 Every cycle, exactly one of lamp_r/lamp_y/lamp_g is set per lane, and at most one lane is non-red.
REQ-029 lamp_g[cur_lane]=1 in GREEN and lamp_y[cur_lane]=1 in YELLOW; all other lanes are red, and every lane is red in ALLRED.

Reset
REQ-030 While rst_n=0, with no clock edge required: state=ALLRED, timer=ALLRED_CYC-1, cur_lane=N_LANES-1, lamp_r all ones, lamp_y=0, lamp_g=0, emg_active=0.
REQ-031 Reset asserted mid-operation forces the REQ-030 values immediately, and any pending preemption is discarded.
REQ-032 After rst_n rises, the first green with SKIP_EMPTY=0 is lane 0, after ALLRED_CYC cycles.

Verification (N_LANES=4, GREEN_CYC=5, YELLOW_CYC=2, ALLRED_CYC=1 unless stated)
REQ-033 Release reset, SKIP_EMPTY=0, no req -> all red for 1 cycle, lane 0 green 5 cycles, yellow 2, all-red 1, then lanes 1, 2, 3, then lane 0 again; period 32 cycles.
REQ-034 SKIP_EMPTY=1, req=4'b0100 -> only lane 2 cycles (8-cycle period); then req=0 -> all red held indefinitely with cur_lane=2.
REQ-035 Lane 0 in green cycle 2, emg_req=1 with emg_lane=3 -> yellow on the next edge for 2 cycles, all-red 1, lane 3 green held with emg_active=1 for 20 cycles; drop emg_req -> lane 3 yellow on the next edge.
REQ-036 emg_req=1 with emg_lane=cur_lane in green -> green held past 5 cycles with emg_active=1; emg_lane=5 instead -> ignored, normal 32-cycle rotation.
REQ-037 rst_n pulled low mid-yellow between clock edges -> lamp_r=4'b1111, lamp_y=0, lamp_g=0 immediately; release -> sequence as REQ-033.
REQ-038 A checker on every cycle of all scenarios confirms REQ-028 holds.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
module traffic_phase_ctrl #(
  parameter int N_LANES    = 4,
  parameter int GREEN_CYC  = 5,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int SKIP_EMPTY = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LANES-1:0] req,
  input  logic               emg_req,
  input  logic [2:0]         emg_lane,
  output logic [N_LANES-1:0] lamp_r,
  output logic [N_LANES-1:0] lamp_y,
  output logic [N_LANES-1:0] lamp_g,
  output logic [2:0]         cur_lane,
  output logic               emg_active
);

  localparam int TMAX_GY = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
  localparam int TMAX    = (TMAX_GY > ALLRED_CYC) ? TMAX_GY : ALLRED_CYC;
  localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef logic [TW-1:0] timer_t;

  localparam timer_t T_GREEN  = timer_t'(GREEN_CYC - 1);
  localparam timer_t T_YELLOW = timer_t'(YELLOW_CYC - 1);
  localparam timer_t T_ALLRED = timer_t'(ALLRED_CYC - 1);

  typedef enum logic [1:0] {
    GREEN,
    YELLOW,
    ALLRED
  } state_t;

  state_t                 state, state_d;
  timer_t                 timer, timer_d;
  logic [2:0]             lane_d;
  logic                   pend, pend_d;
  logic [2:0]             pend_lane, pend_lane_d;
  logic                   emg_valid;
  logic                   emg_hit;
  logic [2:0]             rot_lane;
  logic [2:0]             skip_lane;
  logic                   skip_found;
  logic [2*N_LANES-1:0]   req_rot;
  logic                   emg_active_d;
  logic [N_LANES-1:0]     lamp_r_d, lamp_y_d, lamp_g_d;

  always_comb begin
    emg_valid = emg_req && (int'(emg_lane) < N_LANES);
    emg_hit   = emg_valid && (emg_lane == cur_lane);
    rot_lane  = 3'((32'(cur_lane) + 1) % N_LANES);
  end

  // Requests rotated so bit k is lane cur_lane+1+k; cur_lane itself lands last.
  always_comb begin
    req_rot    = {req, req} >> (32'(cur_lane) + 1);
    skip_found = 1'b0;
    skip_lane  = cur_lane;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (!skip_found && req_rot[k]) begin
        skip_found = 1'b1;
        skip_lane  = 3'((32'(cur_lane) + 1 + k) % N_LANES);
      end
    end
  end

  // A valid preemption seen outside a hold is latched so the next green goes to
  // that lane even if emg_req drops before all-red expires.
  always_comb begin
    state_d     = state;
    timer_d     = timer;
    lane_d      = cur_lane;
    pend_d      = pend;
    pend_lane_d = pend_lane;
    case (state)
      GREEN: begin
        if (emg_hit) begin
          state_d = GREEN;
        end else if (emg_valid) begin
          state_d     = YELLOW;
          timer_d     = T_YELLOW;
          pend_d      = 1'b1;
          pend_lane_d = emg_lane;
        end else if (emg_active || (timer == '0)) begin
          state_d = YELLOW;
          timer_d = T_YELLOW;
        end else begin
          timer_d = timer - timer_t'(1);
        end
      end
      YELLOW: begin
        if (emg_valid) begin
          pend_d      = 1'b1;
          pend_lane_d = emg_lane;
        end
        if (timer == '0) begin
          state_d = ALLRED;
          timer_d = T_ALLRED;
        end else begin
          timer_d = timer - timer_t'(1);
        end
      end
      ALLRED: begin
        if (timer == '0) begin
          timer_d = T_GREEN;
          state_d = GREEN;
          pend_d  = 1'b0;
          if (emg_valid) begin
            lane_d = emg_lane;
          end else if (pend) begin
            lane_d = pend_lane;
          end else if (SKIP_EMPTY != 0) begin
            if (skip_found) begin
              lane_d = skip_lane;
            end else begin
              state_d = ALLRED;
              timer_d = T_ALLRED;
            end
          end else begin
            lane_d = rot_lane;
          end
        end else begin
          if (emg_valid) begin
            pend_d      = 1'b1;
            pend_lane_d = emg_lane;
          end
          timer_d = timer - timer_t'(1);
        end
      end
      default: begin
        state_d = ALLRED;
        timer_d = T_ALLRED;
      end
    endcase
  end

  always_comb begin
    emg_active_d = (state_d == GREEN) && emg_valid && (emg_lane == lane_d);
    lamp_g_d     = '0;
    lamp_y_d     = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      lamp_g_d[i] = (state_d == GREEN)  && (lane_d == 3'(i));
      lamp_y_d[i] = (state_d == YELLOW) && (lane_d == 3'(i));
    end
    lamp_r_d = ~(lamp_g_d | lamp_y_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ALLRED;
      timer      <= T_ALLRED;
      cur_lane   <= 3'(N_LANES - 1);
      pend       <= 1'b0;
      pend_lane  <= '0;
      lamp_r     <= '1;
      lamp_y     <= '0;
      lamp_g     <= '0;
      emg_active <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      cur_lane   <= lane_d;
      pend       <= pend_d;
      pend_lane  <= pend_lane_d;
      lamp_r     <= lamp_r_d;
      lamp_y     <= lamp_y_d;
      lamp_g     <= lamp_g_d;
      emg_active <= emg_active_d;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

  localparam int KG = 0;
  localparam int KY = 1;
  localparam int KA = 2;

  typedef struct {
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] g;
    logic [2:0] lane;
    logic       emg;
  } exp_t;

  logic       clk;
  logic       rst_n, rst1_n;
  logic [3:0] req0, req1;
  logic       emg_req, emg1_req;
  logic [2:0] emg_lane, emg1_lane;

  logic [3:0] r0, y0, g0, r1, y1, g1;
  logic [2:0] lane0, lane1;
  logic       act0, act1;

  exp_t q0[$];
  exp_t q1[$];

  int n_total = 0;
  int n_bad   = 0;

  traffic_phase_ctrl #(
    .N_LANES(4), .GREEN_CYC(5), .YELLOW_CYC(2), .ALLRED_CYC(1), .SKIP_EMPTY(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .emg_req(emg_req), .emg_lane(emg_lane),
    .lamp_r(r0), .lamp_y(y0), .lamp_g(g0), .cur_lane(lane0), .emg_active(act0)
  );

  traffic_phase_ctrl #(
    .N_LANES(4), .GREEN_CYC(5), .YELLOW_CYC(2), .ALLRED_CYC(1), .SKIP_EMPTY(1)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .req(req1), .emg_req(emg1_req), .emg_lane(emg1_lane),
    .lamp_r(r1), .lamp_y(y1), .lamp_g(g1), .cur_lane(lane1), .emg_active(act1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, got running required done");
    $fatal(1);
  end

  task automatic chk(input int d, input logic [3:0] r, input logic [3:0] y, input logic [3:0] g,
                     input logic [2:0] lane, input logic emg);
    exp_t e;
    bit   ok;
    int   nonred;
    ok     = 1'b1;
    nonred = 0;
    for (int i = 0; i < 4; i++) begin
      if ((int'(r[i]) + int'(y[i]) + int'(g[i])) != 1) ok = 1'b0;
      if (!r[i]) nonred++;
    end
    if (nonred > 1) ok = 1'b0;
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL lamp_invariant dut%0d t=%0t got r=%b y=%b g=%b required one lamp per lane, <=1 non-red",
               d, $time, r, y, g);
    end
    if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      n_total++;
      if ({r, y, g, lane, emg} !== {e.r, e.y, e.g, e.lane, e.emg}) begin
        n_bad++;
        $display("FAIL outputs dut%0d t=%0t got r=%b y=%b g=%b lane=%0d emg=%b required r=%b y=%b g=%b lane=%0d emg=%b",
                 d, $time, r, y, g, lane, emg, e.r, e.y, e.g, e.lane, e.emg);
      end
    end
  endtask

  always @(negedge clk) begin
    chk(0, r0, y0, g0, lane0, act0);
    chk(1, r1, y1, g1, lane1, act1);
  end

  task automatic step(input int d, input int kind, input int lane, input bit emg);
    exp_t       e;
    logic [3:0] one;
    one    = 4'b0001 << lane;
    e.g    = (kind == KG) ? one : 4'b0000;
    e.y    = (kind == KY) ? one : 4'b0000;
    e.r    = ~(e.g | e.y);
    e.lane = 3'(lane);
    e.emg  = emg;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input int d, input int kind, input int lane, input bit emg, input int n);
    repeat (n) step(d, kind, lane, emg);
  endtask

  task automatic lane_cycle(input int d, input int lane);
    seg(d, KG, lane, 1'b0, 5);
    seg(d, KY, lane, 1'b0, 2);
    seg(d, KA, lane, 1'b0, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    rst1_n    = 1'b0;
    req0      = '0;
    req1      = '0;
    emg_req   = 1'b0;
    emg_lane  = '0;
    emg1_req  = 1'b0;
    emg1_lane = '0;
    @(posedge clk);
    #1;

    // reset state, then one all-red cycle and the full fixed rotation
    step(0, KA, 3, 1'b0);
    rst_n = 1'b1;
    step(0, KA, 3, 1'b0);
    for (int l = 0; l < 4; l++) lane_cycle(0, l);

    // emergency on the lane already green: hold past 5 cycles
    emg_req  = 1'b1;
    emg_lane = 3'd0;
    seg(0, KG, 0, 1'b0, 1);
    seg(0, KG, 0, 1'b1, 10);
    emg_req = 1'b0;
    seg(0, KG, 0, 1'b1, 1);
    seg(0, KY, 0, 1'b0, 2);
    seg(0, KA, 0, 1'b0, 1);

    // invalid emergency lane is ignored: full 32-cycle rotation
    emg_req  = 1'b1;
    emg_lane = 3'd5;
    for (int k = 1; k <= 4; k++) lane_cycle(0, k % 4);
    emg_req = 1'b0;
    for (int l = 1; l < 4; l++) lane_cycle(0, l);

    // preempt from lane 0 green cycle 2 to lane 3
    seg(0, KG, 0, 1'b0, 1);
    emg_req  = 1'b1;
    emg_lane = 3'd3;
    seg(0, KG, 0, 1'b0, 1);
    seg(0, KY, 0, 1'b0, 2);
    seg(0, KA, 0, 1'b0, 1);
    seg(0, KG, 3, 1'b1, 19);
    emg_req = 1'b0;
    seg(0, KG, 3, 1'b1, 1);
    seg(0, KY, 3, 1'b0, 2);
    seg(0, KA, 3, 1'b0, 1);

    // reset mid-yellow between edges, then restart
    seg(0, KG, 0, 1'b0, 5);
    seg(0, KY, 0, 1'b0, 1);
    rst_n = 1'b0;
    step(0, KA, 3, 1'b0);
    rst_n = 1'b1;
    step(0, KA, 3, 1'b0);
    lane_cycle(0, 0);
    seg(0, KG, 1, 1'b0, 5);

    // skip-empty instance
    req1   = 4'b0100;
    rst1_n = 1'b1;
    step(1, KA, 3, 1'b0);
    lane_cycle(1, 2);
    seg(1, KG, 2, 1'b0, 5);
    seg(1, KY, 2, 1'b0, 2);
    req1 = 4'b0000;
    seg(1, KA, 2, 1'b0, 10);
    req1 = 4'b1001;
    seg(1, KA, 2, 1'b0, 1);
    lane_cycle(1, 3);
    req1 = 4'b1000;
    lane_cycle(1, 0);
    lane_cycle(1, 3);
    seg(1, KG, 3, 1'b0, 1);

    n_total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got q0=%0d q1=%0d required 0 0", q0.size(), q1.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
